// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared op encoding, FSM states and decode helpers for muldiv_sched.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int OP_W      = 4;
    localparam int OP_MUL_LO = 0;
    localparam int OP_REM    = 1;
    localparam int OP_MUL_HI = 2;
    localparam int OP_DIV_Q  = 3;

    localparam logic [63:0] DIV0_QUOT = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_DIV_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } kind_e;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_MUL_LO = 3'd1,
        SEL_REM    = 3'd2,
        SEL_MUL_HI = 3'd3,
        SEL_DIV_Q  = 3'd4
    } sel_e;

    // Lowest set bit wins on a multi-hot op.
    function automatic sel_e op_decode(input logic [OP_W-1:0] op);
        if (op[OP_MUL_LO])     return SEL_MUL_LO;
        else if (op[OP_REM])   return SEL_REM;
        else if (op[OP_MUL_HI]) return SEL_MUL_HI;
        else if (op[OP_DIV_Q]) return SEL_DIV_Q;
        else                   return SEL_NONE;
    endfunction

    function automatic kind_e sel_kind(input sel_e sel);
        if (sel == SEL_REM || sel == SEL_DIV_Q) return KIND_DIV;
        else                                    return KIND_MUL;
    endfunction

    // "High" half is mul_hi for multiplies and the quotient for divides.
    function automatic logic sel_hi(input sel_e sel);
        return (sel == SEL_MUL_HI) || (sel == SEL_DIV_Q);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_reuse_cache.sv
// ============================================================================
// Module : muldiv_reuse_cache
// Brief  : One-entry result-pair cache; compiled only with MULDIV_REUSE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MULDIV_REUSE_EN
module muldiv_reuse_cache
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  kind_e             wr_kind,
    input  logic              wr_sign,
    input  logic [DATA_W-1:0] wr_src1,
    input  logic [DATA_W-1:0] wr_src2,
    input  logic [DATA_W-1:0] wr_hi,
    input  logic [DATA_W-1:0] wr_lo,
    input  kind_e             rd_kind,
    input  logic              rd_sign,
    input  logic [DATA_W-1:0] rd_src1,
    input  logic [DATA_W-1:0] rd_src2,
    output logic              hit,
    output logic [DATA_W-1:0] hit_hi,
    output logic [DATA_W-1:0] hit_lo
);

    logic              r_valid;
    kind_e             r_kind;
    logic              r_sign;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_kind  <= KIND_MUL;
            r_sign  <= 1'b0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_kind  <= wr_kind;
            r_sign  <= wr_sign;
            r_src1  <= wr_src1;
            r_src2  <= wr_src2;
            r_hi    <= wr_hi;
            r_lo    <= wr_lo;
        end
    end

    assign hit    = r_valid && (r_kind == rd_kind) && (r_sign == rd_sign) &&
                    (r_src1 == rd_src1) && (r_src2 == rd_src2);
    assign hit_hi = r_hi;
    assign hit_lo = r_lo;

endmodule
`endif

`default_nettype wire

// File: rtl/muldiv_sched.sv
// ============================================================================
// Module : muldiv_sched
// Brief  : Execute-stage sequencer for the multi-cycle multiplier/divider.
//          Define MULDIV_REUSE_EN to enable the one-entry result-pair reuse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = muldiv_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              mul_in_valid,
    output logic              mul_signed,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    output logic              mul_flush,
    input  logic              mul_out_valid,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    output logic              div_in_valid,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_src1,
    output logic [DATA_W-1:0] div_src2,
    output logic              div_flush,
    input  logic              div_out_valid,
    input  logic [DATA_W-1:0] div_quot,
    input  logic [DATA_W-1:0] div_rem
);

    state_e            r_state;
    state_e            w_state_nxt;
    state_e            w_acc_state;
    sel_e              r_sel;
    sel_e              w_sel;
    logic              r_sign;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_result_nxt;
    logic [DATA_W-1:0] w_acc_result;
    logic              r_busy;
    logic              r_resp_valid;
    logic              r_mul_in_valid;
    logic              r_div_in_valid;
    logic              w_accept;
    logic              w_div0;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    assign w_sel     = op_decode(req_op);
    assign req_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && resp_ready);
    assign w_accept  = req_valid && req_ready && !flush;
    assign w_div0    = (sel_kind(w_sel) == KIND_DIV) && (req_src2 == '0);

`ifdef MULDIV_REUSE_EN
    logic              w_cap;
    kind_e             w_cap_kind;
    logic [DATA_W-1:0] w_cap_hi;
    logic [DATA_W-1:0] w_cap_lo;
    logic [DATA_W-1:0] w_hit_hi;
    logic [DATA_W-1:0] w_hit_lo;

    assign w_cap      = !flush && (((r_state == ST_MUL_WAIT) && mul_out_valid) ||
                                   ((r_state == ST_DIV_WAIT) && div_out_valid));
    assign w_cap_kind = (r_state == ST_DIV_WAIT) ? KIND_DIV : KIND_MUL;
    assign w_cap_hi   = (r_state == ST_DIV_WAIT) ? div_quot : mul_hi;
    assign w_cap_lo   = (r_state == ST_DIV_WAIT) ? div_rem  : mul_lo;

    muldiv_reuse_cache #(
        .DATA_W (DATA_W)
    ) u_reuse_cache (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_cap),
        .wr_kind (w_cap_kind),
        .wr_sign (r_sign),
        .wr_src1 (r_src1),
        .wr_src2 (r_src2),
        .wr_hi   (w_cap_hi),
        .wr_lo   (w_cap_lo),
        .rd_kind (sel_kind(w_sel)),
        .rd_sign (req_sign),
        .rd_src1 (req_src1),
        .rd_src2 (req_src2),
        .hit     (w_hit),
        .hit_hi  (w_hit_hi),
        .hit_lo  (w_hit_lo)
    );

    assign w_hit_data = sel_hi(w_sel) ? w_hit_hi : w_hit_lo;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_comb begin
        // Where a newly accepted op goes: short-circuit to DONE or launch a unit.
        w_acc_state  = ST_LAUNCH;
        w_acc_result = r_result;
        if (w_sel == SEL_NONE) begin
            w_acc_state  = ST_DONE;
            w_acc_result = '0;
        end else if (w_div0) begin
            w_acc_state  = ST_DONE;
            w_acc_result = (w_sel == SEL_REM) ? req_src1 : DIV0_QUOT[DATA_W-1:0];
        end else if (w_hit) begin
            w_acc_state  = ST_DONE;
            w_acc_result = w_hit_data;
        end

        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt  = w_acc_state;
                        w_result_nxt = w_acc_result;
                    end
                end
                ST_LAUNCH: begin
                    w_state_nxt = (sel_kind(r_sel) == KIND_DIV) ? ST_DIV_WAIT : ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (mul_out_valid) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = sel_hi(r_sel) ? mul_hi : mul_lo;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_out_valid) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = sel_hi(r_sel) ? div_quot : div_rem;
                    end
                end
                ST_DONE: begin
                    if (w_accept) begin
                        w_state_nxt  = w_acc_state;
                        w_result_nxt = w_acc_result;
                    end else if (resp_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_sel          <= SEL_NONE;
            r_sign         <= 1'b0;
            r_src1         <= '0;
            r_src2         <= '0;
            r_result       <= '0;
            r_busy         <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_mul_in_valid <= 1'b0;
            r_div_in_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_result       <= w_result_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_resp_valid   <= (w_state_nxt == ST_DONE);
            // LAUNCH is only ever entered from an accept, so w_sel is the live op.
            r_mul_in_valid <= (w_state_nxt == ST_LAUNCH) && (sel_kind(w_sel) == KIND_MUL);
            r_div_in_valid <= (w_state_nxt == ST_LAUNCH) && (sel_kind(w_sel) == KIND_DIV);
            if (w_accept) begin
                r_sel  <= w_sel;
                r_sign <= req_sign;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_result;
    assign busy         = r_busy;
    assign mul_in_valid = r_mul_in_valid;
    assign div_in_valid = r_div_in_valid;
    assign mul_signed   = r_sign;
    assign div_signed   = r_sign;
    assign mul_src1     = r_src1;
    assign mul_src2     = r_src2;
    assign div_src1     = r_src1;
    assign div_src2     = r_src2;
    // Kill is immediate so the unit drops the op in the same cycle as the redirect.
    assign mul_flush    = flush && (r_mul_in_valid || (r_state == ST_MUL_WAIT));
    assign div_flush    = flush && (r_div_in_valid || (r_state == ST_DIV_WAIT));

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// ============================================================================
// Module : tb_muldiv_sched
// Brief  : Directed self-checking bench for muldiv_sched.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_sign;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic        mul_in_valid;
    logic        mul_signed;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_flush;
    logic        mul_out_valid;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        div_in_valid;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        div_out_valid;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sched #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sign(req_sign),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
        .mul_in_valid(mul_in_valid), .mul_signed(mul_signed), .mul_src1(mul_src1),
        .mul_src2(mul_src2), .mul_flush(mul_flush), .mul_out_valid(mul_out_valid),
        .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_in_valid(div_in_valid), .div_signed(div_signed), .div_src1(div_src1),
        .div_src2(div_src2), .div_flush(div_flush), .div_out_valid(div_out_valid),
        .div_quot(div_quot), .div_rem(div_rem)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] op, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_sign  = s;
        req_src1  = a;
        req_src2  = b;
    endtask

    task automatic clr_req;
        req_valid = 1'b0;
        req_op    = 4'b0;
        req_src1  = 32'h0;
        req_src2  = 32'h0;
    endtask

    task automatic release_resp;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks++;
        if ({resp_valid, busy, mul_in_valid, div_in_valid, mul_flush, div_flush, mul_signed, div_signed} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000000",
                     {resp_valid, busy, mul_in_valid, div_in_valid, mul_flush, div_flush, mul_signed, div_signed});
        end
        checks++;
        if ({resp_data, mul_src1, div_src2} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {resp_data, mul_src1, div_src2});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b exp 1", req_ready);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_mul_lo;
        logic bad;
        bad = 1'b0;
        set_req(4'b0001, 1'b1, 32'hFFFF_FFFE, 32'h3);
        tick;
        clr_req;
        checks++;
        if ({mul_in_valid, div_in_valid, busy} !== 3'b101) begin
            errors++;
            $display("FAIL mul_launch got %b exp 101", {mul_in_valid, div_in_valid, busy});
        end
        checks++;
        if ({mul_signed, mul_src1, mul_src2} !== {1'b1, 32'hFFFF_FFFE, 32'h3}) begin
            errors++;
            $display("FAIL mul_operands got %h exp 1fffffffe00000003", {mul_signed, mul_src1, mul_src2});
        end
        for (int c = 2; c <= 6; c++) begin
            tick;
            if (resp_valid !== 1'b0 || busy !== 1'b1 || mul_in_valid !== 1'b0) bad = 1'b1;
            if (c == 6) begin
                mul_out_valid = 1'b1;
                mul_hi        = 32'hFFFF_FFFF;
                mul_lo        = 32'hFFFF_FFFA;
            end
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL mul_wait_window got %b exp 0", bad);
        end
        tick;
        mul_out_valid = 1'b0;
        mul_hi        = 32'h0;
        mul_lo        = 32'h0;
        checks++;
        if ({resp_valid, busy} !== 2'b11 || resp_data !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mul_lo_resp got %b/%h exp 11/fffffffa", {resp_valid, busy}, resp_data);
        end
        release_resp;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL mul_lo_idle got %b exp 00", {resp_valid, busy});
        end
    endtask

    task automatic test_div0;
        set_req(4'b1000, 1'b0, 32'd7, 32'd0);
        tick;
        checks++;
        if ({resp_valid, div_in_valid, mul_in_valid} !== 3'b100 || resp_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div0_quot got %b/%h exp 100/ffffffff", {resp_valid, div_in_valid, mul_in_valid}, resp_data);
        end
        set_req(4'b0010, 1'b0, 32'd7, 32'd0);
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL div0_req_ready got %b exp 1", req_ready);
        end
        tick;
        checks++;
        if ({resp_valid, div_in_valid} !== 2'b10 || resp_data !== 32'd7) begin
            errors++;
            $display("FAIL div0_rem got %b/%h exp 10/00000007", {resp_valid, div_in_valid}, resp_data);
        end
        set_req(4'b0000, 1'b0, 32'd5, 32'd6);
        tick;
        clr_req;
        checks++;
        if ({resp_valid, mul_in_valid, div_in_valid} !== 3'b100 || resp_data !== 32'd0) begin
            errors++;
            $display("FAIL op_zero got %b/%h exp 100/00000000", {resp_valid, mul_in_valid, div_in_valid}, resp_data);
        end
        tick;
        resp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_idle got %b exp 0", busy);
        end
    endtask

    task automatic test_rem_hold;
        logic bad;
        bad = 1'b0;
        set_req(4'b0010, 1'b1, 32'hFFFF_FFF9, 32'd2);
        tick;
        clr_req;
        checks++;
        if ({div_in_valid, mul_in_valid, div_signed} !== 3'b101 || {div_src1, div_src2} !== {32'hFFFF_FFF9, 32'd2}) begin
            errors++;
            $display("FAIL rem_launch got %b/%h exp 101/fffffff900000002", {div_in_valid, mul_in_valid, div_signed}, {div_src1, div_src2});
        end
        tick;
        mul_out_valid = 1'b1;
        mul_lo        = 32'hDEAD_BEEF;
        tick;
        mul_out_valid = 1'b0;
        mul_lo        = 32'h0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rem_stray_mul got %b exp 0", resp_valid);
        end
        tick;
        div_out_valid = 1'b1;
        div_quot      = 32'hFFFF_FFFD;
        div_rem       = 32'hFFFF_FFFF;
        tick;
        div_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rem_resp got %b/%h exp 1/ffffffff", resp_valid, resp_data);
        end
        for (int c = 0; c < 3; c++) begin
            div_out_valid = (c == 0);
            div_quot      = 32'h0;
            div_rem       = 32'h55;
            tick;
            if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || busy !== 1'b1) bad = 1'b1;
        end
        div_out_valid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rem_hold got %b exp 0", bad);
        end
        release_resp;
    endtask

    task automatic test_multi_hot;
        set_req(4'b1100, 1'b0, 32'd2, 32'd3);
        tick;
        clr_req;
        checks++;
        if ({mul_in_valid, div_in_valid} !== 2'b10) begin
            errors++;
            $display("FAIL multihot_mulhi_unit got %b exp 10", {mul_in_valid, div_in_valid});
        end
        tick;
        mul_out_valid = 1'b1;
        mul_hi        = 32'h1234_5678;
        mul_lo        = 32'h9ABC_DEF0;
        tick;
        mul_out_valid = 1'b0;
        checks++;
        if (resp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL multihot_mulhi_data got %h exp 12345678", resp_data);
        end
        set_req(4'b1010, 1'b0, 32'd7, 32'd2);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        clr_req;
        checks++;
        if ({div_in_valid, mul_in_valid} !== 2'b10) begin
            errors++;
            $display("FAIL multihot_rem_unit got %b exp 10", {div_in_valid, mul_in_valid});
        end
        tick;
        div_out_valid = 1'b1;
        div_quot      = 32'd3;
        div_rem       = 32'd1;
        tick;
        div_out_valid = 1'b0;
        checks++;
        if (resp_data !== 32'd1) begin
            errors++;
            $display("FAIL multihot_rem_data got %h exp 00000001", resp_data);
        end
        release_resp;
    endtask

    task automatic test_back_to_back;
        set_req(4'b0001, 1'b0, 32'd6, 32'd7);
        tick;
        clr_req;
        tick;
        mul_out_valid = 1'b1;
        mul_hi        = 32'd0;
        mul_lo        = 32'd42;
        tick;
        mul_out_valid = 1'b0;
        set_req(4'b1000, 1'b0, 32'd100, 32'd7);
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid} !== 2'b11 || resp_data !== 32'd42) begin
            errors++;
            $display("FAIL b2b_accept got %b/%h exp 11/0000002a", {req_ready, resp_valid}, resp_data);
        end
        tick;
        resp_ready = 1'b0;
        clr_req;
        checks++;
        if ({div_in_valid, busy, resp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_launch got %b exp 110", {div_in_valid, busy, resp_valid});
        end
        tick;
        tick;
        div_out_valid = 1'b1;
        div_quot      = 32'd14;
        div_rem       = 32'd2;
        tick;
        div_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd14) begin
            errors++;
            $display("FAIL b2b_data got %b/%h exp 1/0000000e", resp_valid, resp_data);
        end
        release_resp;
    endtask

    task automatic test_flush;
        set_req(4'b1000, 1'b0, 32'd50, 32'd5);
        tick;
        clr_req;
        tick;
        tick;
        flush         = 1'b1;
        set_req(4'b0001, 1'b0, 32'd1, 32'd1);
        div_out_valid = 1'b1;
        div_quot      = 32'd10;
        #1;
        checks++;
        if ({div_flush, mul_flush} !== 2'b10) begin
            errors++;
            $display("FAIL flush_div_pulse got %b exp 10", {div_flush, mul_flush});
        end
        tick;
        flush         = 1'b0;
        clr_req;
        div_out_valid = 1'b0;
        checks++;
        if ({busy, resp_valid, mul_in_valid, div_in_valid, div_flush} !== 5'b00000) begin
            errors++;
            $display("FAIL flush_div_idle got %b exp 00000", {busy, resp_valid, mul_in_valid, div_in_valid, div_flush});
        end
        div_out_valid = 1'b1;
        tick;
        div_out_valid = 1'b0;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_late_valid got %b exp 00", {resp_valid, busy});
        end
        set_req(4'b0001, 1'b0, 32'd3, 32'd4);
        tick;
        clr_req;
        flush = 1'b1;
        #1;
        checks++;
        if ({mul_flush, div_flush} !== 2'b10) begin
            errors++;
            $display("FAIL flush_mul_launch got %b exp 10", {mul_flush, div_flush});
        end
        tick;
        flush = 1'b0;
        checks++;
        if ({busy, mul_flush} !== 2'b00) begin
            errors++;
            $display("FAIL flush_mul_idle got %b exp 00", {busy, mul_flush});
        end
        set_req(4'b0000, 1'b0, 32'd0, 32'd0);
        tick;
        set_req(4'b0001, 1'b0, 32'd8, 32'd9);
        resp_ready = 1'b1;
        flush      = 1'b1;
        tick;
        flush      = 1'b0;
        resp_ready = 1'b0;
        clr_req;
        checks++;
        if ({resp_valid, busy, mul_in_valid} !== 3'b000) begin
            errors++;
            $display("FAIL flush_done_noaccept got %b exp 000", {resp_valid, busy, mul_in_valid});
        end
    endtask

    task automatic test_reuse;
        set_req(4'b0001, 1'b0, 32'h0001_0000, 32'h0001_0000);
        tick;
        clr_req;
        tick;
        mul_out_valid = 1'b1;
        mul_hi        = 32'h1;
        mul_lo        = 32'h0;
        tick;
        mul_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reuse_first got %b/%h exp 1/00000000", resp_valid, resp_data);
        end
        set_req(4'b0100, 1'b0, 32'h0001_0000, 32'h0001_0000);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        clr_req;
`ifdef MULDIV_REUSE_EN
        checks++;
        if ({resp_valid, mul_in_valid} !== 2'b10 || resp_data !== 32'h1) begin
            errors++;
            $display("FAIL reuse_hit got %b/%h exp 10/00000001", {resp_valid, mul_in_valid}, resp_data);
        end
`else
        checks++;
        if ({resp_valid, mul_in_valid} !== 2'b01) begin
            errors++;
            $display("FAIL reuse_relaunch got %b exp 01", {resp_valid, mul_in_valid});
        end
        tick;
        mul_out_valid = 1'b1;
        tick;
        mul_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h1) begin
            errors++;
            $display("FAIL reuse_second got %b/%h exp 1/00000001", resp_valid, resp_data);
        end
`endif
        release_resp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_op        = 4'b0;
        req_sign      = 1'b0;
        req_src1      = 32'h0;
        req_src2      = 32'h0;
        flush         = 1'b0;
        resp_ready    = 1'b0;
        mul_out_valid = 1'b0;
        mul_hi        = 32'h0;
        mul_lo        = 32'h0;
        div_out_valid = 1'b0;
        div_quot      = 32'h0;
        div_rem       = 32'h0;
        test_reset;
        test_mul_lo;
        test_div0;
        test_rem_hold;
        test_multi_hot;
        test_back_to_back;
        test_flush;
        test_reuse;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
